mem_icb_arbiter: RTL and testbench
==================================

# mem_icb_arbiter

Two-master round-robin ICB arbiter that shares the single memory-domain ICB port (`mem_icb_*`, feeding `mem_domain`) between the instruction-fetch unit (port 0) and the load/store unit (port 1). It grants one command per cycle, holds a grant stable while the downstream command is stalled, and tracks up to `OUTS_NUM` outstanding transactions. Responses, which return in order, are steered back to the issuing master.

## Interface
- `AW`, 32, address width.
- `DW`, 32, data width; mask width is `DW/8`.
- `OUTS_NUM`, 1, maximum outstanding transactions (1..4).

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `ifu_icb_cmd_valid` / `ifu_icb_cmd_ready`  in / out  1  port-0 command handshake.
- `ifu_icb_cmd_addr`  in  AW  port-0 address.
- `ifu_icb_rsp_valid` / `ifu_icb_rsp_ready`  out / in  1  port-0 response handshake.
- `ifu_icb_rsp_err`  out  1  port-0 response error.
- `ifu_icb_rsp_rdata`  out  DW  port-0 read data.
- Port 0 is read-only: it is always presented downstream with read=1, wdata=0, wmask=all-ones.
- `lsu_icb_cmd_valid` / `lsu_icb_cmd_ready`  in / out  1  port-1 command handshake.
- `lsu_icb_cmd_addr`  in  AW  port-1 address.
- `lsu_icb_cmd_read`  in  1  port-1 read (1) / write (0).
- `lsu_icb_cmd_wdata`  in  DW  port-1 write data.
- `lsu_icb_cmd_wmask`  in  DW/8  port-1 write byte mask.
- `lsu_icb_rsp_valid` / `lsu_icb_rsp_ready`  out / in  1  port-1 response handshake.
- `lsu_icb_rsp_err`  out  1  port-1 response error.
- `lsu_icb_rsp_rdata`  out  DW  port-1 read data.
- `mem_icb_cmd_valid` / `mem_icb_cmd_ready`  out / in  1  downstream command handshake.
- `mem_icb_cmd_addr`  out  AW  downstream address.
- `mem_icb_cmd_read`  out  1  downstream read/write.
- `mem_icb_cmd_wdata`  out  DW  downstream write data.
- `mem_icb_cmd_wmask`  out  DW/8  downstream write mask.
- `mem_icb_rsp_valid` / `mem_icb_rsp_ready`  in / out  1  downstream response handshake.
- `mem_icb_rsp_err`  in  1  downstream response error.
- `mem_icb_rsp_rdata`  in  DW  downstream read data.

## Operation
- **State:**
  - `rr_last` (1b): last granted port.
  - `lock_vld` / `lock_id`: grant held for a stalled command.
  - `outs_cnt`: width clog2(OUTS_NUM+1).
  - ID FIFO: depth `OUTS_NUM`, 1b entries, with read/write pointers that wrap modulo `OUTS_NUM`.
- **Full** = (`outs_cnt == OUTS_NUM`). When full, `mem_icb_cmd_valid` = 0 and both `*_cmd_ready` = 0. A response retiring in the same cycle does not unblock the command; the slot frees on the next cycle.
- **Arbitration** (when not full and `lock_vld` = 0):
  - Only one port valid: that port is granted.
  - Both ports valid: grant the port ≠ `rr_last`.
  - No port valid: `mem_icb_cmd_valid` = 0.
- **Locked grant:** if `lock_vld` = 1, grant = `lock_id` regardless of the other port.
- **Command mux:** `mem_icb_cmd_*` = granted port's fields. Granted `*_cmd_ready` = `mem_icb_cmd_ready`; the other port's ready = 0.
- **Lock:**
  - Set when `mem_icb_cmd_valid & ~mem_icb_cmd_ready`; `lock_id` = grant.
  - Cleared on the command handshake.
  - A master dropping valid while locked is a protocol violation; behaviour is undefined.
- **On command handshake:** `rr_last` ← grant; push grant ID into the FIFO.
- **On response handshake:** pop the FIFO.
- **`outs_cnt`:**
  - +1 on push only, −1 on pop only.
  - Unchanged on simultaneous push and pop; the FIFO pushes and pops in the same cycle.
- **Response routing:**
  - FIFO non-empty: head ID selects the port. That port's `rsp_valid` = `mem_icb_rsp_valid`; the other port's `rsp_valid` = 0. `rsp_err`/`rsp_rdata` pass through to both ports. `mem_icb_rsp_ready` = head port's `rsp_ready`.
  - FIFO empty: `mem_icb_rsp_ready` = 0 and no `rsp_valid` is raised (a spurious response is held off).
- **Reset (`rst` = 1 at an edge):**
  - `rr_last` ← 1, so port 0 wins the first tie.
  - `lock_vld` ← 0, `outs_cnt` ← 0, FIFO pointers ← 0.
  - While `rst` = 1: `mem_icb_cmd_valid`, both `*_cmd_ready`, both `*_rsp_valid` and `mem_icb_rsp_ready` are forced to 0.
  - Reset mid-transaction discards all tracking; the downstream port is reset with the same `rst`.

## Timing
- Command path is combinational, 0-cycle (master valid → `mem_icb_cmd_valid`); no added latency.
- Response path is combinational, 0-cycle.
- Throughput: one command per cycle while `outs_cnt < OUTS_NUM`.
- With `OUTS_NUM` = 1, the next command can issue no earlier than the cycle after the response handshake.
- Grant fairness: with both ports continuously valid and ready held high, grants alternate every handshake.

## Test plan
- **Reset:** hold `rst` 3 cycles with both masters valid → all valid/ready outputs are 0. After release, with both valid, the first grant is IFU at addr 0x8000_0000.
- **Contention:** `OUTS_NUM`=2, both masters continuously valid, 1-cycle downstream response → handshake grants IFU, LSU, IFU, LSU; each response is returned to the matching port with rdata = addr.
- **Stall lock:** IFU valid with `mem_icb_cmd_ready`=0 for 4 cycles; LSU raises valid in cycle 2 → grant stays IFU until its handshake, then LSU is granted next.
- **Full:** `OUTS_NUM`=1, LSU write 0x8000_0010 issued with the response delayed 5 cycles → `mem_icb_cmd_valid`=0 and IFU `cmd_ready`=0 for those 5 cycles. The IFU command issues in the cycle after the response handshake.
- **Backpressure and error:** LSU `rsp_ready`=0 for 3 cycles while `mem_icb_rsp_valid`=1 with err=1 → `mem_icb_rsp_ready`=0 for those cycles; `lsu_icb_rsp_err`=1 on the handshake; `outs_cnt` returns to 0.
- **Mid-flight reset and spurious response:** assert `rst` with 2 outstanding (`OUTS_NUM`=2) → `outs_cnt`=0 after the reset edge. A subsequent spurious `mem_icb_rsp_valid` with the FIFO empty → `mem_icb_rsp_ready`=0 and no port `rsp_valid` is raised.

Source files
------------

// File: rtl/mem_icb_arbiter.sv
// rtl/mem_icb_arbiter.sv - two-master round-robin ICB arbiter for the memory domain
module mem_icb_arbiter #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int OUTS_NUM = 1
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            ifu_icb_cmd_valid,
    output logic            ifu_icb_cmd_ready,
    input  logic [AW-1:0]   ifu_icb_cmd_addr,
    output logic            ifu_icb_rsp_valid,
    input  logic            ifu_icb_rsp_ready,
    output logic            ifu_icb_rsp_err,
    output logic [DW-1:0]   ifu_icb_rsp_rdata,

    input  logic            lsu_icb_cmd_valid,
    output logic            lsu_icb_cmd_ready,
    input  logic [AW-1:0]   lsu_icb_cmd_addr,
    input  logic            lsu_icb_cmd_read,
    input  logic [DW-1:0]   lsu_icb_cmd_wdata,
    input  logic [DW/8-1:0] lsu_icb_cmd_wmask,
    output logic            lsu_icb_rsp_valid,
    input  logic            lsu_icb_rsp_ready,
    output logic            lsu_icb_rsp_err,
    output logic [DW-1:0]   lsu_icb_rsp_rdata,

    output logic            mem_icb_cmd_valid,
    input  logic            mem_icb_cmd_ready,
    output logic [AW-1:0]   mem_icb_cmd_addr,
    output logic            mem_icb_cmd_read,
    output logic [DW-1:0]   mem_icb_cmd_wdata,
    output logic [DW/8-1:0] mem_icb_cmd_wmask,
    input  logic            mem_icb_rsp_valid,
    output logic            mem_icb_rsp_ready,
    input  logic            mem_icb_rsp_err,
    input  logic [DW-1:0]   mem_icb_rsp_rdata
);

    localparam int CW = $clog2(OUTS_NUM + 1);
    localparam int PW = (OUTS_NUM > 1) ? $clog2(OUTS_NUM) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(OUTS_NUM);
    localparam logic [PW-1:0] PTR_MAX = PW'(OUTS_NUM - 1);

    // Arbitration / tracking state. Port id 0 = IFU, 1 = LSU.
    logic          rr_last_q,  rr_last_d;
    logic          lock_vld_q, lock_vld_d;
    logic          lock_id_q,  lock_id_d;
    logic [CW-1:0] outs_cnt_q, outs_cnt_d;
    logic [PW-1:0] wptr_q,     wptr_d;
    logic [PW-1:0] rptr_q,     rptr_d;
    logic          id_fifo_q [OUTS_NUM];

    logic grant;
    logic gnt_valid;
    logic full;
    logic fifo_nempty;
    logic head_id;
    logic cmd_hsk;
    logic rsp_hsk;

    // The outstanding counter doubles as the ID FIFO occupancy.
    assign full        = (outs_cnt_q == CNT_MAX);
    assign fifo_nempty = (outs_cnt_q != '0);
    assign head_id     = id_fifo_q[rptr_q];

    // Grant select: a held lock wins, otherwise round-robin on a tie.
    always_comb begin
        grant = 1'b0;
        if (lock_vld_q) begin
            grant = lock_id_q;
        end else if (ifu_icb_cmd_valid && lsu_icb_cmd_valid) begin
            grant = ~rr_last_q;
        end else if (lsu_icb_cmd_valid) begin
            grant = 1'b1;
        end
    end

    assign gnt_valid = grant ? lsu_icb_cmd_valid : ifu_icb_cmd_valid;

    // Command path: fully combinational, blocked while full or in reset.
    assign mem_icb_cmd_valid = ~rst & ~full & gnt_valid;
    assign ifu_icb_cmd_ready = ~rst & ~full & ~grant & mem_icb_cmd_ready;
    assign lsu_icb_cmd_ready = ~rst & ~full &  grant & mem_icb_cmd_ready;

    // IFU only ever reads a full word.
    assign mem_icb_cmd_addr  = grant ? lsu_icb_cmd_addr  : ifu_icb_cmd_addr;
    assign mem_icb_cmd_read  = grant ? lsu_icb_cmd_read  : 1'b1;
    assign mem_icb_cmd_wdata = grant ? lsu_icb_cmd_wdata : '0;
    assign mem_icb_cmd_wmask = grant ? lsu_icb_cmd_wmask : '1;

    assign cmd_hsk = mem_icb_cmd_valid & mem_icb_cmd_ready;

    // Response path: the FIFO head steers the in-order response; with no
    // tracked transaction any response is held off.
    assign ifu_icb_rsp_valid = ~rst & fifo_nempty & ~head_id & mem_icb_rsp_valid;
    assign lsu_icb_rsp_valid = ~rst & fifo_nempty &  head_id & mem_icb_rsp_valid;
    assign mem_icb_rsp_ready = ~rst & fifo_nempty &
                               (head_id ? lsu_icb_rsp_ready : ifu_icb_rsp_ready);
    assign ifu_icb_rsp_err   = mem_icb_rsp_err;
    assign lsu_icb_rsp_err   = mem_icb_rsp_err;
    assign ifu_icb_rsp_rdata = mem_icb_rsp_rdata;
    assign lsu_icb_rsp_rdata = mem_icb_rsp_rdata;

    assign rsp_hsk = mem_icb_rsp_valid & mem_icb_rsp_ready;

    // Next-state for round-robin, lock, pointers and outstanding count.
    always_comb begin
        rr_last_d  = rr_last_q;
        lock_vld_d = lock_vld_q;
        lock_id_d  = lock_id_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        outs_cnt_d = outs_cnt_q;

        if (cmd_hsk) begin
            rr_last_d  = grant;
            lock_vld_d = 1'b0;
            wptr_d     = (wptr_q == PTR_MAX) ? '0 : wptr_q + 1'b1;
        end else if (mem_icb_cmd_valid) begin
            lock_vld_d = 1'b1;
            lock_id_d  = grant;
        end

        if (rsp_hsk) begin
            rptr_d = (rptr_q == PTR_MAX) ? '0 : rptr_q + 1'b1;
        end

        if (cmd_hsk && !rsp_hsk) begin
            outs_cnt_d = outs_cnt_q + 1'b1;
        end else if (!cmd_hsk && rsp_hsk) begin
            outs_cnt_d = outs_cnt_q - 1'b1;
        end
    end

    // State register; rr_last resets to LSU so IFU wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_last_q  <= 1'b1;
            lock_vld_q <= 1'b0;
            lock_id_q  <= 1'b0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            outs_cnt_q <= '0;
        end else begin
            rr_last_q  <= rr_last_d;
            lock_vld_q <= lock_vld_d;
            lock_id_q  <= lock_id_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            outs_cnt_q <= outs_cnt_d;
        end
    end

    // ID FIFO storage: record which port issued each accepted command.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < OUTS_NUM; i++) begin
                id_fifo_q[i] <= 1'b0;
            end
        end else if (cmd_hsk) begin
            id_fifo_q[wptr_q] <= grant;
        end
    end

endmodule

// File: tb/tb_mem_icb_arbiter.sv
// tb/tb_mem_icb_arbiter.sv - scoreboard bench for mem_icb_arbiter
module tb_mem_icb_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic [31:0] addr;
        logic        read;
        logic [31:0] wdata;
        logic [3:0]  wmask;
    } cmd_t;

    typedef struct {
        logic [31:0] addr;
        logic        err;
        int          due;
    } pend_t;

    // instance A: OUTS_NUM = 2
    logic        rst = 1'b1;
    logic        ifu_icb_cmd_valid = 1'b0;
    logic        ifu_icb_cmd_ready;
    logic [31:0] ifu_icb_cmd_addr = '0;
    logic        ifu_icb_rsp_valid;
    logic        ifu_icb_rsp_ready = 1'b0;
    logic        ifu_icb_rsp_err;
    logic [31:0] ifu_icb_rsp_rdata;
    logic        lsu_icb_cmd_valid = 1'b0;
    logic        lsu_icb_cmd_ready;
    logic [31:0] lsu_icb_cmd_addr = '0;
    logic        lsu_icb_cmd_read = 1'b1;
    logic [31:0] lsu_icb_cmd_wdata = '0;
    logic [3:0]  lsu_icb_cmd_wmask = '0;
    logic        lsu_icb_rsp_valid;
    logic        lsu_icb_rsp_ready = 1'b0;
    logic        lsu_icb_rsp_err;
    logic [31:0] lsu_icb_rsp_rdata;
    logic        mem_icb_cmd_valid;
    logic        mem_icb_cmd_ready = 1'b0;
    logic [31:0] mem_icb_cmd_addr;
    logic        mem_icb_cmd_read;
    logic [31:0] mem_icb_cmd_wdata;
    logic [3:0]  mem_icb_cmd_wmask;
    logic        mem_icb_rsp_valid = 1'b0;
    logic        mem_icb_rsp_ready;
    logic        mem_icb_rsp_err = 1'b0;
    logic [31:0] mem_icb_rsp_rdata = '0;

    // instance B: OUTS_NUM = 1
    logic        b_rst = 1'b1;
    logic        b_ifu_cmd_valid = 1'b0;
    logic        b_ifu_cmd_ready;
    logic [31:0] b_ifu_cmd_addr = '0;
    logic        b_ifu_rsp_valid;
    logic        b_ifu_rsp_ready = 1'b0;
    logic        b_ifu_rsp_err;
    logic [31:0] b_ifu_rsp_rdata;
    logic        b_lsu_cmd_valid = 1'b0;
    logic        b_lsu_cmd_ready;
    logic [31:0] b_lsu_cmd_addr = '0;
    logic        b_lsu_cmd_read = 1'b1;
    logic [31:0] b_lsu_cmd_wdata = '0;
    logic [3:0]  b_lsu_cmd_wmask = '0;
    logic        b_lsu_rsp_valid;
    logic        b_lsu_rsp_ready = 1'b0;
    logic        b_lsu_rsp_err;
    logic [31:0] b_lsu_rsp_rdata;
    logic        b_mem_cmd_valid;
    logic        b_mem_cmd_ready = 1'b0;
    logic [31:0] b_mem_cmd_addr;
    logic        b_mem_cmd_read;
    logic [31:0] b_mem_cmd_wdata;
    logic [3:0]  b_mem_cmd_wmask;
    logic        b_mem_rsp_valid = 1'b0;
    logic        b_mem_rsp_ready;
    logic        b_mem_rsp_err = 1'b0;
    logic [31:0] b_mem_rsp_rdata = '0;

    mem_icb_arbiter #(.AW(32), .DW(32), .OUTS_NUM(2)) dut_a (
        .clk(clk), .rst(rst),
        .ifu_icb_cmd_valid(ifu_icb_cmd_valid), .ifu_icb_cmd_ready(ifu_icb_cmd_ready),
        .ifu_icb_cmd_addr(ifu_icb_cmd_addr),
        .ifu_icb_rsp_valid(ifu_icb_rsp_valid), .ifu_icb_rsp_ready(ifu_icb_rsp_ready),
        .ifu_icb_rsp_err(ifu_icb_rsp_err), .ifu_icb_rsp_rdata(ifu_icb_rsp_rdata),
        .lsu_icb_cmd_valid(lsu_icb_cmd_valid), .lsu_icb_cmd_ready(lsu_icb_cmd_ready),
        .lsu_icb_cmd_addr(lsu_icb_cmd_addr), .lsu_icb_cmd_read(lsu_icb_cmd_read),
        .lsu_icb_cmd_wdata(lsu_icb_cmd_wdata), .lsu_icb_cmd_wmask(lsu_icb_cmd_wmask),
        .lsu_icb_rsp_valid(lsu_icb_rsp_valid), .lsu_icb_rsp_ready(lsu_icb_rsp_ready),
        .lsu_icb_rsp_err(lsu_icb_rsp_err), .lsu_icb_rsp_rdata(lsu_icb_rsp_rdata),
        .mem_icb_cmd_valid(mem_icb_cmd_valid), .mem_icb_cmd_ready(mem_icb_cmd_ready),
        .mem_icb_cmd_addr(mem_icb_cmd_addr), .mem_icb_cmd_read(mem_icb_cmd_read),
        .mem_icb_cmd_wdata(mem_icb_cmd_wdata), .mem_icb_cmd_wmask(mem_icb_cmd_wmask),
        .mem_icb_rsp_valid(mem_icb_rsp_valid), .mem_icb_rsp_ready(mem_icb_rsp_ready),
        .mem_icb_rsp_err(mem_icb_rsp_err), .mem_icb_rsp_rdata(mem_icb_rsp_rdata)
    );

    mem_icb_arbiter #(.AW(32), .DW(32), .OUTS_NUM(1)) dut_b (
        .clk(clk), .rst(b_rst),
        .ifu_icb_cmd_valid(b_ifu_cmd_valid), .ifu_icb_cmd_ready(b_ifu_cmd_ready),
        .ifu_icb_cmd_addr(b_ifu_cmd_addr),
        .ifu_icb_rsp_valid(b_ifu_rsp_valid), .ifu_icb_rsp_ready(b_ifu_rsp_ready),
        .ifu_icb_rsp_err(b_ifu_rsp_err), .ifu_icb_rsp_rdata(b_ifu_rsp_rdata),
        .lsu_icb_cmd_valid(b_lsu_cmd_valid), .lsu_icb_cmd_ready(b_lsu_cmd_ready),
        .lsu_icb_cmd_addr(b_lsu_cmd_addr), .lsu_icb_cmd_read(b_lsu_cmd_read),
        .lsu_icb_cmd_wdata(b_lsu_cmd_wdata), .lsu_icb_cmd_wmask(b_lsu_cmd_wmask),
        .lsu_icb_rsp_valid(b_lsu_rsp_valid), .lsu_icb_rsp_ready(b_lsu_rsp_ready),
        .lsu_icb_rsp_err(b_lsu_rsp_err), .lsu_icb_rsp_rdata(b_lsu_rsp_rdata),
        .mem_icb_cmd_valid(b_mem_cmd_valid), .mem_icb_cmd_ready(b_mem_cmd_ready),
        .mem_icb_cmd_addr(b_mem_cmd_addr), .mem_icb_cmd_read(b_mem_cmd_read),
        .mem_icb_cmd_wdata(b_mem_cmd_wdata), .mem_icb_cmd_wmask(b_mem_cmd_wmask),
        .mem_icb_rsp_valid(b_mem_rsp_valid), .mem_icb_rsp_ready(b_mem_rsp_ready),
        .mem_icb_rsp_err(b_mem_rsp_err), .mem_icb_rsp_rdata(b_mem_rsp_rdata)
    );

    // bench-side state for instance A
    logic [31:0] ifu_cmds [$];
    cmd_t        lsu_cmds [$];
    pend_t       pend [$];
    cmd_t        exp_grant [$];
    logic [32:0] exp_ifu [$];
    logic [32:0] exp_lsu [$];
    logic        rst_v = 1'b1;
    logic        mem_rdy_v = 1'b0;
    logic        ifu_rr_v = 1'b0;
    logic        lsu_rr_v = 1'b0;
    logic        err_v = 1'b0;
    logic        spur = 1'b0;
    int          rsp_delay = 0;
    int          cyc = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic send_ifu(input logic [31:0] addr, input bit want_rsp);
        cmd_t g;
        ifu_cmds.push_back(addr);
        g.addr = addr; g.read = 1'b1; g.wdata = '0; g.wmask = 4'hF;
        exp_grant.push_back(g);
        if (want_rsp) exp_ifu.push_back({1'b0, addr});
    endtask

    // The grant order is pushed by whoever calls this, in hand-computed order.
    task automatic queue_lsu(input logic [31:0] addr, input logic rd, input logic [31:0] wd,
                             input logic [3:0] wm, input logic err, input bit want_rsp);
        cmd_t c;
        c.addr = addr; c.read = rd; c.wdata = wd; c.wmask = wm;
        lsu_cmds.push_back(c);
        if (want_rsp) exp_lsu.push_back({err, addr});
    endtask

    task automatic exp_lsu_grant(input logic [31:0] addr, input logic rd, input logic [31:0] wd,
                                 input logic [3:0] wm);
        cmd_t g;
        g.addr = addr; g.read = rd; g.wdata = wd; g.wmask = wm;
        exp_grant.push_back(g);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (n < 200 && !(exp_grant.size() == 0 && exp_ifu.size() == 0 &&
                            exp_lsu.size() == 0 && pend.size() == 0)) begin
            step();
            n++;
        end
        chk(name, 64'(n < 200), 64'(1));
        step();
    endtask

    // Masters and memory model for A: bookkeeping on negedge, drive after posedge.
    initial begin
        pend_t p;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst) begin
                if (ifu_icb_cmd_valid && ifu_icb_cmd_ready) void'(ifu_cmds.pop_front());
                if (lsu_icb_cmd_valid && lsu_icb_cmd_ready) void'(lsu_cmds.pop_front());
                if (mem_icb_rsp_valid && mem_icb_rsp_ready && pend.size() > 0)
                    void'(pend.pop_front());
                if (mem_icb_cmd_valid && mem_icb_cmd_ready) begin
                    p.addr = mem_icb_cmd_addr;
                    p.err  = err_v;
                    p.due  = cyc + rsp_delay;
                    pend.push_back(p);
                end
            end
            @(posedge clk);
            #1;
            rst = rst_v;
            ifu_icb_cmd_valid = (ifu_cmds.size() > 0);
            if (ifu_cmds.size() > 0) ifu_icb_cmd_addr = ifu_cmds[0];
            lsu_icb_cmd_valid = (lsu_cmds.size() > 0);
            if (lsu_cmds.size() > 0) begin
                lsu_icb_cmd_addr  = lsu_cmds[0].addr;
                lsu_icb_cmd_read  = lsu_cmds[0].read;
                lsu_icb_cmd_wdata = lsu_cmds[0].wdata;
                lsu_icb_cmd_wmask = lsu_cmds[0].wmask;
            end
            mem_icb_cmd_ready = mem_rdy_v;
            ifu_icb_rsp_ready = ifu_rr_v;
            lsu_icb_rsp_ready = lsu_rr_v;
            if (spur) begin
                mem_icb_rsp_valid = 1'b1;
                mem_icb_rsp_rdata = 32'hDEAD_BEEF;
                mem_icb_rsp_err   = 1'b0;
            end else if (pend.size() > 0 && pend[0].due <= cyc) begin
                mem_icb_rsp_valid = 1'b1;
                mem_icb_rsp_rdata = pend[0].addr;
                mem_icb_rsp_err   = pend[0].err;
            end else begin
                mem_icb_rsp_valid = 1'b0;
            end
        end
    end

    // Scoreboard monitor for A
    initial begin
        cmd_t g;
        logic [32:0] e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (mem_icb_cmd_valid && mem_icb_cmd_ready) begin
                    if (exp_grant.size() == 0) begin
                        n_checks++; n_errors++;
                        $display("FAIL grant_unexpected: got addr %h expected none", mem_icb_cmd_addr);
                    end else begin
                        g = exp_grant.pop_front();
                        chk("grant_addr", 64'(mem_icb_cmd_addr), 64'(g.addr));
                        chk("grant_fields", 64'({mem_icb_cmd_read, mem_icb_cmd_wmask, mem_icb_cmd_wdata}),
                            64'({g.read, g.wmask, g.wdata}));
                    end
                end
                if (ifu_icb_rsp_valid && ifu_icb_rsp_ready) begin
                    if (exp_ifu.size() == 0) begin
                        n_checks++; n_errors++;
                        $display("FAIL ifu_rsp_unexpected: got %h expected none", ifu_icb_rsp_rdata);
                    end else begin
                        e = exp_ifu.pop_front();
                        chk("ifu_rsp", 64'({ifu_icb_rsp_err, ifu_icb_rsp_rdata}), 64'(e));
                    end
                end
                if (lsu_icb_rsp_valid && lsu_icb_rsp_ready) begin
                    if (exp_lsu.size() == 0) begin
                        n_checks++; n_errors++;
                        $display("FAIL lsu_rsp_unexpected: got %h expected none", lsu_icb_rsp_rdata);
                    end else begin
                        e = exp_lsu.pop_front();
                        chk("lsu_rsp", 64'({lsu_icb_rsp_err, lsu_icb_rsp_rdata}), 64'(e));
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // reset with both masters requesting, then contention IFU,LSU,IFU,LSU
        rsp_delay = 0; mem_rdy_v = 1'b1; ifu_rr_v = 1'b1; lsu_rr_v = 1'b1;
        send_ifu(32'h8000_0000, 1'b1);
        queue_lsu(32'h8000_1000, 1'b1, 32'h0, 4'hF, 1'b0, 1'b1);
        exp_lsu_grant(32'h8000_1000, 1'b1, 32'h0, 4'hF);
        send_ifu(32'h8000_0004, 1'b1);
        queue_lsu(32'h8000_1004, 1'b1, 32'h0, 4'hF, 1'b0, 1'b1);
        exp_lsu_grant(32'h8000_1004, 1'b1, 32'h0, 4'hF);
        step();
        for (int i = 0; i < 3; i++) begin
            step();
            chk("reset_outputs", 64'({mem_icb_cmd_valid, ifu_icb_cmd_ready, lsu_icb_cmd_ready,
                                      ifu_icb_rsp_valid, lsu_icb_rsp_valid, mem_icb_rsp_ready}), 64'(0));
        end
        rst_v = 1'b0;
        wait_idle("contention_done");

        // IFU alone so that rr_last points at IFU before the stall
        send_ifu(32'h8000_000C, 1'b1);
        wait_idle("ifu_single_done");

        // stall lock: LSU would win a fresh tie, but the lock keeps IFU
        mem_rdy_v = 1'b0;
        send_ifu(32'h8000_0100, 1'b1);
        exp_lsu_grant(32'h8000_1100, 1'b0, 32'h1234_5678, 4'h3);
        step();
        chk("stall_c1", 64'({mem_icb_cmd_valid, mem_icb_cmd_addr}), 64'({1'b1, 32'h8000_0100}));
        queue_lsu(32'h8000_1100, 1'b0, 32'h1234_5678, 4'h3, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_lock", 64'({mem_icb_cmd_valid, mem_icb_cmd_addr}), 64'({1'b1, 32'h8000_0100}));
        end
        mem_rdy_v = 1'b1;
        wait_idle("stall_done");

        // response backpressure with error
        lsu_rr_v = 1'b0; err_v = 1'b1;
        queue_lsu(32'h8000_1200, 1'b1, 32'h0, 4'hF, 1'b1, 1'b1);
        exp_lsu_grant(32'h8000_1200, 1'b1, 32'h0, 4'hF);
        n = 0;
        while (!mem_icb_rsp_valid && n < 20) begin
            step();
            n++;
        end
        chk("bp_rsp_arrived", 64'(n < 20), 64'(1));
        for (int i = 0; i < 3; i++) begin
            chk("bp_mem_rsp_ready", 64'(mem_icb_rsp_ready), 64'(0));
            chk("bp_lsu_rsp_valid", 64'({lsu_icb_rsp_valid, ifu_icb_rsp_valid}), 64'(2'b10));
            if (i < 2) step();
        end
        lsu_rr_v = 1'b1; err_v = 1'b0;
        wait_idle("bp_done");
        chk("bp_outs_cnt", 64'(dut_a.outs_cnt_q), 64'(0));

        // mid-flight reset with two outstanding
        rsp_delay = 10;
        send_ifu(32'h8000_0300, 1'b0);
        queue_lsu(32'h8000_1300, 1'b1, 32'h0, 4'hF, 1'b0, 1'b0);
        exp_lsu_grant(32'h8000_1300, 1'b1, 32'h0, 4'hF);
        n = 0;
        while (exp_grant.size() > 0 && n < 20) begin
            step();
            n++;
        end
        step();
        chk("mid_outs_cnt_2", 64'(dut_a.outs_cnt_q), 64'(2));
        rst_v = 1'b1; pend.delete(); rsp_delay = 0;
        step();
        rst_v = 1'b0;
        step();
        chk("mid_outs_cnt_0", 64'(dut_a.outs_cnt_q), 64'(0));

        // spurious response with nothing tracked
        spur = 1'b1;
        step();
        chk("spur_mem_rsp_ready", 64'(mem_icb_rsp_ready), 64'(0));
        chk("spur_rsp_valid", 64'({ifu_icb_rsp_valid, lsu_icb_rsp_valid}), 64'(0));
        spur = 1'b0;
        step();
        step();
        chk("drained", 64'({exp_grant.size() == 0, exp_ifu.size() == 0, exp_lsu.size() == 0}),
            64'(3'b111));

        // instance B (OUTS_NUM=1): full blocks IFU until after the response
        @(posedge clk); #1;
        b_rst = 1'b0; b_mem_cmd_ready = 1'b1; b_lsu_rsp_ready = 1'b1; b_ifu_rsp_ready = 1'b1;
        b_lsu_cmd_valid = 1'b1; b_lsu_cmd_addr = 32'h8000_0010; b_lsu_cmd_read = 1'b0;
        b_lsu_cmd_wdata = 32'hCAFE_F00D; b_lsu_cmd_wmask = 4'hF;
        @(negedge clk);
        chk("b_wr_cmd", 64'({b_mem_cmd_valid, b_mem_cmd_read, b_lsu_cmd_ready, b_ifu_cmd_ready}),
            64'(4'b1010));
        chk("b_wr_addr", 64'(b_mem_cmd_addr), 64'(32'h8000_0010));
        chk("b_wr_data", 64'({b_mem_cmd_wmask, b_mem_cmd_wdata}), 64'({4'hF, 32'hCAFE_F00D}));
        @(posedge clk); #1;
        b_lsu_cmd_valid = 1'b0;
        b_ifu_cmd_valid = 1'b1; b_ifu_cmd_addr = 32'h8000_0020;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("b_full_block", 64'({b_mem_cmd_valid, b_ifu_cmd_ready}), 64'(0));
            @(posedge clk); #1;
        end
        b_mem_rsp_valid = 1'b1; b_mem_rsp_rdata = 32'h8000_0010; b_mem_rsp_err = 1'b0;
        @(negedge clk);
        chk("b_rsp_route", 64'({b_lsu_rsp_valid, b_ifu_rsp_valid, b_mem_rsp_ready}), 64'(3'b101));
        chk("b_rsp_data", 64'({b_lsu_rsp_err, b_lsu_rsp_rdata}), 64'({1'b0, 32'h8000_0010}));
        chk("b_same_cycle_block", 64'({b_mem_cmd_valid, b_ifu_cmd_ready}), 64'(0));
        @(posedge clk); #1;
        b_mem_rsp_valid = 1'b0;
        @(negedge clk);
        chk("b_ifu_issue", 64'({b_mem_cmd_valid, b_ifu_cmd_ready, b_mem_cmd_read}), 64'(3'b111));
        chk("b_ifu_addr", 64'(b_mem_cmd_addr), 64'(32'h8000_0020));
        chk("b_ifu_fields", 64'({b_mem_cmd_wmask, b_mem_cmd_wdata}), 64'({4'hF, 32'h0}));
        @(posedge clk); #1;
        b_ifu_cmd_valid = 1'b0;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
